// File: rtl/synth_slot_sequencer_if.sv
// Note-event ready/valid bus into the slot sequencer's event FIFO.
interface synth_slot_sequencer_if #(
   parameter int V_WIDTH = 3
);
   logic               evt_valid;
   logic               evt_ready;
   logic               evt_on;
   logic [V_WIDTH-1:0] evt_key_adr;
   logic [7:0]         evt_key_val;
   logic [7:0]         evt_vel;

   modport master (
      output evt_valid, evt_on, evt_key_adr, evt_key_val, evt_vel,
      input  evt_ready
   );

   modport slave (
      input  evt_valid, evt_on, evt_key_adr, evt_key_val, evt_vel,
      output evt_ready
   );
endinterface

// File: rtl/synth_slot_sequencer.sv
// Slot-index generator, per-frame note-event release FIFO and note-flag delay line.
// Optional statistics ports (stall counter, FIFO level) are enabled by SLOT_SEQ_STATS_EN.
module synth_slot_sequencer #(
   parameter int VOICES    = 8,
   parameter int V_OSC     = 4,
   parameter int O_ENVS    = 2,
   parameter int V_WIDTH   = 3,
   parameter int O_WIDTH   = 2,
   parameter int OE_WIDTH  = 1,
   parameter int SLOT_DIV  = 1,
   parameter int EVT_DEPTH = 4,
   parameter int NOTE_DLY  = 3
) (
   input  logic                                OSC_CLK,
   input  logic                                iRST,
   synth_slot_sequencer_if.slave               evt,
   input  logic [VOICES-1:0]                   keys_on,
   output logic [V_WIDTH+O_WIDTH+OE_WIDTH-1:0] xxxx,
   output logic                                slot_stb,
   output logic                                frame_start,
   output logic                                cur_evt_valid,
   output logic                                cur_evt_on,
   output logic [V_WIDTH-1:0]                  cur_key_adr,
   output logic [7:0]                          cur_key_val,
   output logic [7:0]                          cur_vel,
   output logic [VOICES-1:0]                   reg_keys_on,
   output logic [NOTE_DLY-1:0]                 note_on_dly
`ifdef SLOT_SEQ_STATS_EN
   ,
   output logic [15:0]                         evt_stall_cnt,
   output logic [$clog2(EVT_DEPTH):0]          fifo_level
`endif
);

   localparam int TOTAL = VOICES * V_OSC * O_ENVS;
   localparam int SW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int DW    = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
   localparam int PW    = $clog2(EVT_DEPTH);
   localparam int XW    = V_WIDTH + O_WIDTH + OE_WIDTH;

   typedef struct packed {
      logic               on;
      logic [V_WIDTH-1:0] adr;
      logic [7:0]         key;
      logic [7:0]         vel;
   } evt_t;

   function automatic logic [XW-1:0] slot_index(input logic [SW-1:0] s);
      int si;
      si = int'(s);
      return {V_WIDTH'(si / (V_OSC * O_ENVS)), O_WIDTH'((si / O_ENVS) % V_OSC),
              OE_WIDTH'(si % O_ENVS)};
   endfunction

   logic [DW-1:0] div_cnt;
   logic [SW-1:0] slot;
   logic [SW-1:0] slot_nxt;
   logic          tick;
   logic          frame_edge;

   assign tick       = (div_cnt == DW'(SLOT_DIV - 1));
   assign slot_nxt   = (slot == SW'(TOTAL - 1)) ? '0 : slot + SW'(1);
   assign frame_edge = tick & (slot_nxt == '0);

   // Slot timing: counter idles at the last slot so the first tick opens a frame
   always_ff @(posedge OSC_CLK) begin
      if (iRST) begin
         div_cnt     <= '0;
         slot        <= SW'(TOTAL - 1);
         xxxx        <= '0;
         slot_stb    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         div_cnt     <= tick ? '0 : div_cnt + DW'(1);
         slot_stb    <= tick;
         frame_start <= frame_edge;
         if (tick) begin
            slot <= slot_nxt;
            xxxx <= slot_index(slot_nxt);
         end
      end
   end

   evt_t          mem [EVT_DEPTH];
   evt_t          head;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   // Ready reflects occupancy before this edge's pop, so a full FIFO never takes a push
   assign full          = (count == (PW+1)'(EVT_DEPTH));
   assign empty         = (count == '0);
   assign evt.evt_ready = ~full;
   assign push          = evt.evt_valid & ~full;
   assign pop           = frame_edge & ~empty;
   assign head          = mem[rd_ptr];

   always_ff @(posedge OSC_CLK) begin
      if (push) mem[wr_ptr] <= '{on: evt.evt_on, adr: evt.evt_key_adr,
                                 key: evt.evt_key_val, vel: evt.evt_vel};
   end

   always_ff @(posedge OSC_CLK) begin
      if (iRST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Release stage: one event per frame; an empty frame keeps the last key data
   always_ff @(posedge OSC_CLK) begin
      if (iRST) begin
         cur_evt_valid <= 1'b0;
         cur_evt_on    <= 1'b0;
         cur_key_adr   <= '0;
         cur_key_val   <= '0;
         cur_vel       <= '0;
         reg_keys_on   <= '0;
         note_on_dly   <= '0;
      end else begin
         note_on_dly <= NOTE_DLY'({note_on_dly, cur_evt_valid & cur_evt_on});
         if (frame_edge) begin
            cur_evt_valid <= ~empty;
            cur_evt_on    <= ~empty & head.on;
            reg_keys_on   <= keys_on;
            if (!empty) begin
               cur_key_adr <= head.adr;
               cur_key_val <= head.key;
               cur_vel     <= head.vel;
            end
         end
      end
   end

`ifdef SLOT_SEQ_STATS_EN
   assign fifo_level = count;

   always_ff @(posedge OSC_CLK) begin
      if (iRST)                                            evt_stall_cnt <= '0;
      else if (evt.evt_valid && full && evt_stall_cnt != 16'hFFFF) evt_stall_cnt <= evt_stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_synth_slot_sequencer.sv
// Directed bench: slot timing at SLOT_DIV 1 and 3, event release, FIFO full, reset flush.
module tb_synth_slot_sequencer;

   logic       clk;
   logic       rst;
   logic [1:0] keys_a;
   logic [1:0] keys_b;
   int         checks;
   int         fails;
   int         n;

   logic [2:0] xxxx_a, xxxx_b;
   logic       stb_a, stb_b, fs_a, fs_b;
   logic       cv_a, cv_b, con_a, con_b;
   logic       cadr_a, cadr_b;
   logic [7:0] ckey_a, ckey_b, cvel_a, cvel_b;
   logic [1:0] rk_a, rk_b;
   logic [2:0] dly_a, dly_b;
`ifdef SLOT_SEQ_STATS_EN
   logic [15:0] stall_a, stall_b;
   logic [2:0]  lvl_a, lvl_b;
`endif

   synth_slot_sequencer_if #(.V_WIDTH(1)) ia ();
   synth_slot_sequencer_if #(.V_WIDTH(1)) ib ();

   synth_slot_sequencer #(
      .VOICES(2), .V_OSC(2), .O_ENVS(2), .V_WIDTH(1), .O_WIDTH(1), .OE_WIDTH(1),
      .SLOT_DIV(1), .EVT_DEPTH(4), .NOTE_DLY(3)
   ) dut_a (
      .OSC_CLK(clk), .iRST(rst), .evt(ia.slave), .keys_on(keys_a),
      .xxxx(xxxx_a), .slot_stb(stb_a), .frame_start(fs_a),
      .cur_evt_valid(cv_a), .cur_evt_on(con_a), .cur_key_adr(cadr_a),
      .cur_key_val(ckey_a), .cur_vel(cvel_a), .reg_keys_on(rk_a), .note_on_dly(dly_a)
`ifdef SLOT_SEQ_STATS_EN
      , .evt_stall_cnt(stall_a), .fifo_level(lvl_a)
`endif
   );

   synth_slot_sequencer #(
      .VOICES(2), .V_OSC(2), .O_ENVS(2), .V_WIDTH(1), .O_WIDTH(1), .OE_WIDTH(1),
      .SLOT_DIV(3), .EVT_DEPTH(4), .NOTE_DLY(3)
   ) dut_b (
      .OSC_CLK(clk), .iRST(rst), .evt(ib.slave), .keys_on(keys_b),
      .xxxx(xxxx_b), .slot_stb(stb_b), .frame_start(fs_b),
      .cur_evt_valid(cv_b), .cur_evt_on(con_b), .cur_key_adr(cadr_b),
      .cur_key_val(ckey_b), .cur_vel(cvel_b), .reg_keys_on(rk_b), .note_on_dly(dly_b)
`ifdef SLOT_SEQ_STATS_EN
      , .evt_stall_cnt(stall_b), .fifo_level(lvl_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic step_to(input int t);
      while (n < t) step();
   endtask

   task automatic offer(input logic v, input logic on, input logic adr,
                        input logic [7:0] key, input logic [7:0] vel);
      ia.evt_valid   = v;
      ia.evt_on      = on;
      ia.evt_key_adr = adr;
      ia.evt_key_val = key;
      ia.evt_vel     = vel;
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      n      = 0;
      rst    = 1'b1;
      keys_a = 2'b00;
      keys_b = 2'b00;
      offer(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      ib.evt_valid = 1'b0; ib.evt_on = 1'b0; ib.evt_key_adr = 1'b0;
      ib.evt_key_val = 8'd0; ib.evt_vel = 8'd0;

      // Reset state
      step();
      step();
      chk("rst_xxxx_a", 32'(xxxx_a), 32'd0);
      chk("rst_stb_a", 32'(stb_a), 32'd0);
      chk("rst_fs_a", 32'(fs_a), 32'd0);
      chk("rst_ready_a", 32'(ia.evt_ready), 32'd1);
      chk("rst_cv_a", 32'(cv_a), 32'd0);
      chk("rst_dly_a", 32'(dly_a), 32'd0);
      chk("rst_stb_b", 32'(stb_b), 32'd0);
      chk("rst_ready_b", 32'(ib.evt_ready), 32'd1);
      rst = 1'b0;
      n   = 0;

      // Slot sweep: A ticks every edge, B every third edge
      for (int i = 1; i <= 27; i++) begin
         step();
         chk("a_xxxx", 32'(xxxx_a), 32'((i - 1) % 8));
         chk("a_stb", 32'(stb_a), 32'd1);
         chk("a_fs", 32'(fs_a), 32'((i - 1) % 8 == 0));
         chk("b_xxxx", 32'(xxxx_b), (i < 3) ? 32'd0 : 32'((i / 3 - 1) % 8));
         chk("b_stb", 32'(stb_b), 32'(i % 3 == 0));
         chk("b_fs", 32'(fs_b), 32'(i == 3 || i == 27));
      end

      // Single note-on pushed mid-frame
      offer(1'b1, 1'b1, 1'b1, 8'd60, 8'd100);
      step();
      offer(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      keys_a = 2'b10;
      step_to(32);
      chk("pre_cv", 32'(cv_a), 32'd0);
      chk("pre_ready", 32'(ia.evt_ready), 32'd1);
      step();
      chk("rel_fs", 32'(fs_a), 32'd1);
      chk("rel_cv", 32'(cv_a), 32'd1);
      chk("rel_on", 32'(con_a), 32'd1);
      chk("rel_adr", 32'(cadr_a), 32'd1);
      chk("rel_key", 32'(ckey_a), 32'd60);
      chk("rel_vel", 32'(cvel_a), 32'd100);
      chk("rel_keys", 32'(rk_a), 32'b10);
      chk("dly_0", 32'(dly_a), 32'b000);
      step();
      chk("dly_1", 32'(dly_a), 32'b001);
      keys_a = 2'b01;
      step();
      chk("dly_2", 32'(dly_a), 32'b011);
      step();
      chk("dly_3", 32'(dly_a), 32'b111);
      step_to(40);
      chk("hold_cv", 32'(cv_a), 32'd1);
      chk("hold_keys", 32'(rk_a), 32'b10);
      step();
      chk("empty_fs", 32'(fs_a), 32'd1);
      chk("empty_cv", 32'(cv_a), 32'd0);
      chk("empty_on", 32'(con_a), 32'd0);
      chk("empty_key_held", 32'(ckey_a), 32'd60);
      chk("empty_keys", 32'(rk_a), 32'b01);

      // Five back-to-back events into a 4-deep FIFO
      offer(1'b1, 1'b1, 1'b0, 8'd10, 8'd20);
      step();
      chk("dly_fall", 32'(dly_a), 32'b110);
      offer(1'b1, 1'b1, 1'b1, 8'd11, 8'd21);
      step();
      offer(1'b1, 1'b1, 1'b0, 8'd12, 8'd22);
      step();
      offer(1'b1, 1'b0, 1'b1, 8'd13, 8'd23);
      step();
      chk("full_ready", 32'(ia.evt_ready), 32'd0);
      offer(1'b1, 1'b1, 1'b0, 8'd14, 8'd24);
      step_to(48);
      chk("stall_ready", 32'(ia.evt_ready), 32'd0);
      step();
      chk("pop0_fs", 32'(fs_a), 32'd1);
      chk("pop0_key", 32'(ckey_a), 32'd10);
      chk("pop0_vel", 32'(cvel_a), 32'd20);
      chk("pop0_ready", 32'(ia.evt_ready), 32'd1);
      step();
      offer(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      chk("refill_ready", 32'(ia.evt_ready), 32'd0);
`ifdef SLOT_SEQ_STATS_EN
      chk("stall_cnt", 32'(stall_a), 32'd4);
      chk("fifo_level", 32'(lvl_a), 32'd4);
`endif
      step_to(57);
      chk("pop1_key", 32'(ckey_a), 32'd11);
      chk("pop1_adr", 32'(cadr_a), 32'd1);
      chk("pop1_ready", 32'(ia.evt_ready), 32'd1);
      step_to(65);
      chk("pop2_key", 32'(ckey_a), 32'd12);
      step_to(73);
      chk("pop3_key", 32'(ckey_a), 32'd13);
      chk("pop3_cv", 32'(cv_a), 32'd1);
      chk("pop3_off", 32'(con_a), 32'd0);
      step_to(81);
      chk("pop4_key", 32'(ckey_a), 32'd14);
      chk("pop4_on", 32'(con_a), 32'd1);

      // Push into an empty FIFO on the frame-start edge
      step_to(88);
      offer(1'b1, 1'b1, 1'b1, 8'd77, 8'd5);
      step();
      offer(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      chk("fsp_fs", 32'(fs_a), 32'd1);
      chk("fsp_cv", 32'(cv_a), 32'd0);
      chk("fsp_key_held", 32'(ckey_a), 32'd14);
      step_to(97);
      chk("fsp_next_cv", 32'(cv_a), 32'd1);
      chk("fsp_next_key", 32'(ckey_a), 32'd77);

      // Reset mid-frame with two events queued
      offer(1'b1, 1'b1, 1'b0, 8'd90, 8'd1);
      step();
      offer(1'b1, 1'b1, 1'b1, 8'd91, 8'd2);
      step();
      offer(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      step_to(101);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst_xxxx", 32'(xxxx_a), 32'd0);
      chk("mrst_ready", 32'(ia.evt_ready), 32'd1);
      chk("mrst_cv", 32'(cv_a), 32'd0);
      chk("mrst_fs", 32'(fs_a), 32'd0);
      chk("mrst_key", 32'(ckey_a), 32'd0);
      for (int i = 103; i <= 120; i++) begin
         step();
         chk("post_xxxx", 32'(xxxx_a), 32'((i - 103) % 8));
         chk("post_fs", 32'(fs_a), 32'((i - 103) % 8 == 0));
         chk("post_cv", 32'(cv_a), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/synth_slot_sequencer.md
Name: synth_slot_sequencer

Overview:
- Parametrised successor to the engine's fixed-size slot timing and note-event capture logic.
- Generates the time-multiplexed slot index {voice, osc, env} for any VOICES × V_OSC × O_ENVS geometry, with a programmable slot-rate divider.
- Buffers incoming note events in a ready/valid FIFO and releases at most one event per frame, aligned to slot 0.
- Provides a parametric delay line of the released note flag for downstream pitch, osc, env and mixer pipelines.

Parameters:
- VOICES, 8, voices per frame
- V_OSC, 4, oscillators per voice
- O_ENVS, 2, envelope slots per oscillator
- V_WIDTH, 3, voice index width, clog2(VOICES)
- O_WIDTH, 2, osc index width, clog2(V_OSC)
- OE_WIDTH, 1, env-per-osc index width, clog2(O_ENVS)
- SLOT_DIV, 1, OSC_CLK cycles per slot (≥1)
- EVT_DEPTH, 4, event FIFO entries (power of 2, ≥2)
- NOTE_DLY, 3, taps of note-flag delay line (≥1)

Ports:
- OSC_CLK  in  1  sole clock
- iRST  in  1  synchronous reset, active-high
- evt_valid  in  1  note event offered
- evt_ready  out  1  FIFO can accept (= !full)
- evt_on  in  1  1 = note on, 0 = note off
- evt_key_adr  in  V_WIDTH  target voice
- evt_key_val  in  8  MIDI key
- evt_vel  in  8  velocity
- keys_on  in  VOICES  live key bitmap
- xxxx  out  V_WIDTH+O_WIDTH+OE_WIDTH  current slot {voice, osc, env}
- slot_stb  out  1  one-cycle pulse when xxxx updates
- frame_start  out  1  one-cycle pulse when xxxx updates to 0
- cur_evt_valid  out  1  event released this frame (held for the frame)
- cur_evt_on  out  1  released event type
- cur_key_adr  out  V_WIDTH  released voice
- cur_key_val  out  8  released key
- cur_vel  out  8  released velocity
- reg_keys_on  out  VOICES  keys_on snapshot taken at frame start
- note_on_dly  out  NOTE_DLY  bit k = cur_evt_valid & cur_evt_on delayed k+1 cycles

Behaviour:
- TOTAL = VOICES*V_OSC*O_ENVS.
- Divider:
  - div_cnt counts 0..SLOT_DIV-1.
  - tick = (div_cnt == SLOT_DIV-1).
  - With SLOT_DIV=1, tick is asserted every cycle.
- Slot counter:
  - Internal slot counter resets to TOTAL-1.
  - On tick: next = (slot == TOTAL-1) ? 0 : slot+1.
  - xxxx is registered: voice = next / (V_OSC*O_ENVS), osc = (next / O_ENVS) % V_OSC, env = next % O_ENVS, packed MSB→LSB.
  - slot_stb <= tick.
  - frame_start <= tick & (next == 0).
- Reset values: all outputs 0, except evt_ready = 1 (FIFO empty).
  - The first edge after iRST deasserts with tick set produces xxxx=0, slot_stb=1, frame_start=1.
- FIFO:
  - Push on evt_valid & evt_ready; stores {on, adr, key, vel}.
  - Pop only on the edge that sets frame_start, and only if the FIFO is non-empty.
  - evt_ready is decided before any pop: when full, a push is refused even on a pop cycle.
  - Push and pop on the same edge: the count is unchanged.
  - An event pushed on a frame-start edge into an empty FIFO is not released that frame; it is released next frame.
  - Read and write pointers wrap modulo EVT_DEPTH.
- Release, on the frame_start edge:
  - Non-empty FIFO: cur_evt_valid <= 1; cur_* <= head entry.
  - Empty FIFO: cur_evt_valid <= 0, cur_evt_on <= 0; adr/key/vel hold their previous values.
  - reg_keys_on <= keys_on on every frame_start edge.
  - All cur_* and reg_keys_on are stable between frame starts.
- Delay line: note_on_dly shifts every OSC_CLK cycle, independent of tick.
- Reset mid-operation: all registers return to their reset values on the next edge; FIFO contents are discarded; the frame restarts from slot 0.

Optional Feature:
- Macro: SLOT_SEQ_STATS_EN.
- Defined:
  - Adds output evt_stall_cnt[15:0], saturating at 16'hFFFF, incremented on each cycle with evt_valid & !evt_ready.
  - Adds output fifo_level[clog2(EVT_DEPTH):0], giving the current occupancy.
  - Both reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Geometry VOICES=2, V_OSC=2, O_ENVS=2, SLOT_DIV=1; release reset -> xxxx steps 0..7 on consecutive cycles; frame_start every 8th cycle; first frame_start on the first edge after iRST=0.
- SLOT_DIV=3, same geometry -> slot_stb every 3 cycles; frame_start every 24 cycles; xxxx constant between strobes.
- Push one note-on (adr=1, key=60, vel=100) mid-frame -> at next frame_start: cur_evt_valid=1, cur_key_val=60; note_on_dly[0] high 1 cycle later, note_on_dly[2] high 3 cycles later; cur_evt_valid=0 at the following frame_start.
- EVT_DEPTH=4: push 5 events back to back -> evt_ready low after 4 accepted; events released one per frame in push order; evt_ready reasserts after the first pop; with SLOT_SEQ_STATS_EN, evt_stall_cnt equals the stalled cycles.
- Push into an empty FIFO on the frame_start edge -> not released that frame; released at the next frame_start.
- Assert iRST for 1 cycle mid-frame with 2 events queued -> xxxx=0 and evt_ready=1 afterwards; no queued event is ever released; frame restarts from slot 0.
